// File: rtl/fpdiv_if.sv
// Operand, rounding-mode and result bundle for the sequential floating-point divider.
interface fpdiv_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 7
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic [W-1:0] x_in;
  logic [W-1:0] y_in;
  logic [1:0]   round_in;
  logic         start_in;
  logic [W-1:0] q_out;
  logic [3:0]   oor_out;
  logic         valid_out;
  logic         ready_out;

  modport master (
    output x_in, y_in, round_in, start_in,
    input  q_out, oor_out, valid_out, ready_out
  );

  modport slave (
    input  x_in, y_in, round_in, start_in,
    output q_out, oor_out, valid_out, ready_out
  );
endinterface

// File: rtl/fpdiv.sv
// Sequential floating-point divider: restoring division, one quotient bit per clock,
// followed by a single normalise/round/special-case cycle.
module fpdiv #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 7
) (
  input  logic    clk_in,
  input  logic    rst_in_N,
  fpdiv_if.slave  bus
);
  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int N     = FRAC_W + 3;
  localparam int CNT_W = $clog2(N);
  localparam int EW    = EXP_W + 2;
  localparam int R_W   = FRAC_W + 2;

  localparam logic signed [EW-1:0] BIAS   = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] E_TOP  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);
  localparam logic [EXP_W-1:0]     EXP_ONES = '1;
  localparam logic [EXP_W-1:0]     EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, ITER, ROUND} state_t;

  state_t             state_reg, state_next;
  logic [W-1:0]       x_reg, y_reg;
  logic [1:0]         rm_reg;
  logic [R_W-1:0]     rem_reg;
  logic [N-1:0]       quo_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [W-1:0]       q_out_reg;
  logic [3:0]         oor_reg;
  logic               valid_reg;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_in) begin
    if (!rst_in_N) state_reg <= IDLE;
    else           state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start_in) state_next = ITER;
      ITER:    if (cnt_reg == CNT_W'(N - 1)) state_next = ROUND;
      ROUND:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- restoring division step ----------------
  logic [R_W-1:0] divisor, rem_diff, rem_step;
  logic           take_bit;

  always_comb begin
    divisor  = {1'b0, 1'b1, y_reg[FRAC_W-1:0]};
    take_bit = (rem_reg >= divisor);
    rem_diff = take_bit ? (rem_reg - divisor) : rem_reg;
    // rem_diff < divisor < 2^(FRAC_W+1), so the shift never loses a set bit
    rem_step = rem_diff << 1;
  end

  // ---------------- normalise, round, special cases ----------------
  logic [EXP_W-1:0]     x_exp, y_exp;
  logic [FRAC_W-1:0]    x_frac, y_frac;
  logic                 x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic                 sign, guard, sticky, away, inc;
  logic [FRAC_W-1:0]    mant, frac_rnd;
  logic [FRAC_W:0]      mant_sum;
  logic signed [EW-1:0] e_raw, e_norm, e_rnd;
  logic [W-1:0]         inf_word, res_q;
  logic [3:0]           res_oor;

  always_comb begin
    x_exp  = x_reg[W-2:FRAC_W];
    y_exp  = y_reg[W-2:FRAC_W];
    x_frac = x_reg[FRAC_W-1:0];
    y_frac = y_reg[FRAC_W-1:0];
    x_zero = (x_exp == '0);
    y_zero = (y_exp == '0);
    x_inf  = (x_exp == EXP_ONES) && (x_frac == '0);
    y_inf  = (y_exp == EXP_ONES) && (y_frac == '0);
    x_nan  = (x_exp == EXP_ONES) && (x_frac != '0);
    y_nan  = (y_exp == EXP_ONES) && (y_frac != '0);
    sign   = x_reg[W-1] ^ y_reg[W-1];
    inf_word = {sign, EXP_ONES, {FRAC_W{1'b0}}};

    e_raw = $signed({2'b00, x_exp}) - $signed({2'b00, y_exp}) + BIAS;
    if (quo_reg[N-1]) begin
      mant   = quo_reg[N-2:2];
      guard  = quo_reg[1];
      sticky = quo_reg[0] | (|rem_reg);
      e_norm = e_raw;
    end else begin
      mant   = quo_reg[N-3:1];
      guard  = quo_reg[0];
      sticky = |rem_reg;
      e_norm = e_raw - E_ONE;
    end

    away = ((rm_reg == 2'b10) && !sign) || ((rm_reg == 2'b11) && sign);
    if (rm_reg == 2'b00) inc = guard & (sticky | mant[0]);
    else                 inc = away & (guard | sticky);

    mant_sum = {1'b0, mant} + {{FRAC_W{1'b0}}, inc};
    if (mant_sum[FRAC_W]) begin
      frac_rnd = '0;
      e_rnd    = e_norm + E_ONE;
    end else begin
      frac_rnd = mant_sum[FRAC_W-1:0];
      e_rnd    = e_norm;
    end

    res_q   = {sign, e_rnd[EXP_W-1:0], frac_rnd};
    res_oor = 4'b0000;
    if (x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf)) begin
      res_q   = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
      res_oor = 4'b1000;
    end else if (y_zero && !x_inf) begin
      res_q   = inf_word;
      res_oor = 4'b0100;
    end else if (x_inf) begin
      res_q   = inf_word;
    end else if (y_inf || x_zero) begin
      res_q   = {sign, {(W-1){1'b0}}};
    end else if (e_rnd >= E_TOP) begin
      // saturate to max-finite only when rounding heads toward zero
      res_q   = ((rm_reg == 2'b00) || away) ? inf_word : {sign, EXP_MAXF, {FRAC_W{1'b1}}};
      res_oor = 4'b0001;
    end else if (e_rnd <= E_ZERO) begin
      res_q   = {sign, {(W-1){1'b0}}};
      res_oor = 4'b0010;
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk_in) begin
    if (!rst_in_N) begin
      x_reg     <= '0;
      y_reg     <= '0;
      rm_reg    <= '0;
      rem_reg   <= '0;
      quo_reg   <= '0;
      cnt_reg   <= '0;
      q_out_reg <= '0;
      oor_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start_in) begin
            x_reg   <= bus.x_in;
            y_reg   <= bus.y_in;
            rm_reg  <= bus.round_in;
            rem_reg <= {1'b0, 1'b1, bus.x_in[FRAC_W-1:0]};
            quo_reg <= '0;
            cnt_reg <= '0;
          end
        end
        ITER: begin
          quo_reg <= {quo_reg[N-2:0], take_bit};
          rem_reg <= rem_step;
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
        ROUND: begin
          q_out_reg <= res_q;
          oor_reg   <= res_oor;
          valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.q_out     = q_out_reg;
  assign bus.oor_out   = oor_reg;
  assign bus.valid_out = valid_reg;
  assign bus.ready_out = (state_reg == IDLE);
endmodule

// File: tb/tb_fpdiv.sv
// Self-checking bench for fpdiv: directed vectors, randomized operands against an
// exact integer-division reference model, handshake and mid-division reset.
module tb_fpdiv;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 7;
  localparam int W      = 16;
  localparam int LAT    = 12;

  logic clk_in   = 1'b0;
  logic rst_in_N = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  fpdiv_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) bus ();
  fpdiv #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
    .clk_in  (clk_in),
    .rst_in_N(rst_in_N),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  // Reference: one wide integer division of the significands, then IEEE-style rounding.
  function automatic void ref_div(input logic [15:0] x, input logic [15:0] y,
                                  input logic [1:0] rm,
                                  output logic [15:0] q, output logic [3:0] oor);
    int     ex, ey, fx, fy, e, sh;
    bit     sg, xz, yz, xi, yi, xn, yn, g, s, away, inc;
    longint num, qi, rem, mant;
    ex = int'(x[14:7]); fx = int'(x[6:0]);
    ey = int'(y[14:7]); fy = int'(y[6:0]);
    sg = x[15] ^ y[15];
    xz = (ex == 0);   yz = (ey == 0);
    xi = (ex == 255 && fx == 0); yi = (ey == 255 && fy == 0);
    xn = (ex == 255 && fx != 0); yn = (ey == 255 && fy != 0);
    oor = 4'b0000;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      q = 16'h7FC0; oor = 4'b1000;
    end else if (yz && !xi) begin
      q = {sg, 15'h7F80}; oor = 4'b0100;
    end else if (xi) begin
      q = {sg, 15'h7F80};
    end else if (yi || xz) begin
      q = {sg, 15'h0000};
    end else begin
      num = longint'(128 + fx) <<< 20;
      qi  = num / longint'(128 + fy);
      rem = num % longint'(128 + fy);
      e   = ex - ey + 127;
      if (qi >= (64'sd1 <<< 20)) sh = 13;
      else begin sh = 12; e = e - 1; end
      mant = qi >>> sh;
      g    = ((qi >>> (sh - 1)) & 1) != 0;
      s    = ((qi & ((64'sd1 <<< (sh - 1)) - 1)) != 0) || (rem != 0);
      away = (rm == 2'b10 && !sg) || (rm == 2'b11 && sg);
      inc  = (rm == 2'b00) ? (g && (s || mant[0])) : (away && (g || s));
      mant = mant + (inc ? 1 : 0);
      if (mant == 256) begin mant = 128; e = e + 1; end
      if (e >= 255) begin
        oor = 4'b0001;
        q = (rm == 2'b00 || away) ? {sg, 15'h7F80} : {sg, 15'h7F7F};
      end else if (e <= 0) begin
        oor = 4'b0010; q = {sg, 15'h0000};
      end else begin
        q = {sg, 8'(e), 7'(mant)};
      end
    end
  endfunction

  function automatic logic [15:0] rand_op();
    int e, f;
    case ($urandom_range(0, 7))
      0:       e = 0;
      1:       e = 255;
      2:       e = $urandom_range(1, 20);
      3:       e = $urandom_range(235, 254);
      default: e = $urandom_range(1, 254);
    endcase
    f = (e == 255 && $urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 127);
    return {1'($urandom), 8'(e), 7'(f)};
  endfunction

  // Wait up to 20 edges after the accepting edge; returns the edge number of valid_out (0 = none).
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk_in); #1;
      if (bus.valid_out) begin lat = k; break; end
    end
  endtask

  task automatic run_div(input logic [15:0] x, input logic [15:0] y, input logic [1:0] rm,
                         input logic [15:0] exp_q, input logic [3:0] exp_oor, input string tag);
    int lat;
    @(negedge clk_in);
    bus.x_in = x; bus.y_in = y; bus.round_in = rm; bus.start_in = 1'b1;
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    check({tag, " ready_low"}, 16'(bus.ready_out), 16'd0);
    bus.x_in = 16'($urandom); bus.y_in = 16'($urandom); bus.round_in = 2'($urandom);
    wait_valid(lat);
    check({tag, " latency"}, 16'(lat), 16'(LAT));
    check({tag, " q"}, bus.q_out, exp_q);
    check({tag, " oor"}, 16'(bus.oor_out), 16'(exp_oor));
    check({tag, " ready_done"}, 16'(bus.ready_out), 16'd1);
    $display("%s: 0x%04h / 0x%04h rm=%0d -> q=0x%04h oor=%04b (exp 0x%04h %04b)",
             tag, x, y, rm, bus.q_out, bus.oor_out, exp_q, exp_oor);
    @(posedge clk_in); #1;
    check({tag, " valid_pulse"}, 16'(bus.valid_out), 16'd0);
  endtask

  initial begin
    logic [15:0] x, y, eq;
    logic [3:0]  eo;
    logic [1:0]  rm;
    int          lat, pulses;

    bus.x_in = '0; bus.y_in = '0; bus.round_in = '0; bus.start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check("reset q", bus.q_out, 16'h0000);
    check("reset oor", 16'(bus.oor_out), 16'h0000);
    check("reset valid", 16'(bus.valid_out), 16'd0);
    check("reset ready", 16'(bus.ready_out), 16'd1);
    @(negedge clk_in) rst_in_N = 1'b1;

    // directed vectors
    run_div(16'h40C0, 16'h4040, 2'b00, 16'h4000, 4'b0000, "six_by_three");
    run_div(16'h3F80, 16'h4040, 2'b00, 16'h3EAB, 4'b0000, "third_rne");
    run_div(16'h3F80, 16'h4040, 2'b01, 16'h3EAA, 4'b0000, "third_rtz");
    run_div(16'hBF80, 16'h4040, 2'b11, 16'hBEAB, 4'b0000, "negthird_rdn");
    run_div(16'hBF80, 16'h4040, 2'b10, 16'hBEAA, 4'b0000, "negthird_rup");
    run_div(16'h3F80, 16'h0000, 2'b00, 16'h7F80, 4'b0100, "div_zero");
    run_div(16'h0000, 16'h0000, 2'b00, 16'h7FC0, 4'b1000, "zero_zero");
    run_div(16'h7F80, 16'h7F80, 2'b00, 16'h7FC0, 4'b1000, "inf_inf");
    run_div(16'hC000, 16'h7F80, 2'b00, 16'h8000, 4'b0000, "fin_inf");
    run_div(16'h7F00, 16'h3F00, 2'b00, 16'h7F80, 4'b0001, "ovf_rne");
    run_div(16'h7F00, 16'h3F00, 2'b01, 16'h7F7F, 4'b0001, "ovf_rtz");
    run_div(16'h0080, 16'h4000, 2'b00, 16'h0000, 4'b0010, "unf");

    // randomized against the reference model
    for (int i = 0; i < 300; i++) begin
      x = rand_op(); y = rand_op(); rm = 2'($urandom);
      ref_div(x, y, rm, eq, eo);
      run_div(x, y, rm, eq, eo, $sformatf("rnd%0d", i));
    end

    // start held high: one acceptance, back-to-back start in the valid cycle
    @(negedge clk_in);
    bus.x_in = 16'h40C0; bus.y_in = 16'h4040; bus.round_in = 2'b00; bus.start_in = 1'b1;
    @(posedge clk_in); #1;
    wait_valid(lat);
    check("held latency1", 16'(lat), 16'(LAT));
    check("held q1", bus.q_out, 16'h4000);
    $display("held1: q=0x%04h latency=%0d", bus.q_out, lat);
    bus.x_in = 16'h3F80; bus.y_in = 16'h4040;
    @(posedge clk_in); #1;
    check("held accept2", 16'(bus.ready_out), 16'd0);
    bus.start_in = 1'b0;
    bus.x_in = 16'($urandom); bus.y_in = 16'($urandom);
    wait_valid(lat);
    check("held latency2", 16'(lat), 16'(LAT));
    check("held q2", bus.q_out, 16'h3EAB);
    $display("held2: q=0x%04h latency=%0d", bus.q_out, lat);
    @(posedge clk_in); #1;

    // reset at edge 5 of a division
    @(negedge clk_in);
    bus.x_in = 16'h40C0; bus.y_in = 16'h4040; bus.round_in = 2'b00; bus.start_in = 1'b1;
    @(posedge clk_in); #1;
    bus.start_in = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in) rst_in_N = 1'b0;
    @(posedge clk_in); #1;
    check("abort valid", 16'(bus.valid_out), 16'd0);
    check("abort q", bus.q_out, 16'h0000);
    check("abort oor", 16'(bus.oor_out), 16'h0000);
    check("abort ready", 16'(bus.ready_out), 16'd1);
    @(negedge clk_in) rst_in_N = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk_in); #1;
      if (bus.valid_out) pulses++;
    end
    check("abort no_result", 16'(pulses), 16'd0);
    $display("abort: valid pulses after reset = %0d", pulses);
    run_div(16'h3F80, 16'h4040, 2'b00, 16'h3EAB, 4'b0000, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpdiv.md
Name: fpdiv

Overview:
Sequential floating-point divider, the inverse operation of the team's shift-add multiplier. Computes q = x / y on sign/exponent/fraction words using restoring division, one quotient bit per clock. Uses the same start/ready/valid handshake, rounding-mode encoding and out-of-range vector as the multiplier. The two blocks sit side by side in the arithmetic unit.

Parameters:
EXP_W, 8, exponent field width; bias = 2^(EXP_W-1)-1 (127 at default)
FRAC_W, 7, stored fraction width; word width W = 1+EXP_W+FRAC_W (16 at default, bit W-1 = sign)

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in_N  input  1  reset, synchronous and active-low
x_in  input  W  dividend {sign, exponent, fraction}
y_in  input  W  divisor {sign, exponent, fraction}
round_in  input  2  rounding mode: 00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf
start_in  input  1  request a division; accepted only while ready_out=1
q_out  output  W  quotient; held until the next result is written
oor_out  output  4  [0] overflow, [1] underflow, [2] divide-by-zero, [3] invalid
valid_out  output  1  one-cycle pulse; q_out and oor_out are new this cycle
ready_out  output  1  block idle, can accept start_in

Behaviour:
- Reset (rst_in_N=0 at an edge): state IDLE; q_out=0, oor_out=0, valid_out=0, ready_out=1. Reset aborts any division in flight and no result is produced.
- States and transitions:
  - IDLE: ready_out=1. An edge with start_in=1 captures x_in, y_in and round_in, sets ready_out=0 and moves to ITER.
  - ITER: lasts N = FRAC_W+3 edges (10 at default). Each edge produces one quotient bit (MSB first) by restoring division of 1.fx by 1.fy, then moves to ROUND.
  - ROUND: one edge. Normalises, rounds, resolves special cases, writes q_out and oor_out, sets valid_out=1 and ready_out=1, moves to IDLE.
- valid_out clears on the next edge.
- Fixed latency for every operand, special cases included: valid_out is high in the cycle after the (N+2)th edge counted from the accepting edge (the accepting edge is edge 1). That is 12 edges at default.
- start_in while ready_out=0 is ignored. start_in in the cycle where valid_out=1 is accepted normally (ready_out is already 1).
- Sign = sx XOR sy.
- Exponent is signed arithmetic, EXP_W+2 bits wide: e = ex - ey + bias.
- Quotient q[N-1:0] lies in (0.5, 2).
  - If q[N-1]=1: mantissa = q[N-2:2], guard = q[1], sticky = q[0] OR (remainder ≠ 0).
  - Else: mantissa = q[N-3:1], guard = q[0], sticky = (remainder ≠ 0), and e = e-1.
- Rounding:
  - Nearest-even: increment when guard=1 AND (sticky=1 OR mantissa LSB=1).
  - Directed modes: increment when (guard OR sticky) is set and the rounding direction moves away from zero for this sign.
  - If the mantissa carries out of FRAC_W bits, fraction becomes 0 and e = e+1.
- Overflow, e ≥ 2^EXP_W-1: oor_out[0]=1.
  - Result is signed infinity for nearest-even, and for a directed mode that rounds away from zero for this sign.
  - Otherwise the result is signed max-finite (exponent all-ones minus 1, fraction all-ones).
- Underflow, e ≤ 0: signed zero (flush-to-zero), oor_out[1]=1.
- Operand classes: exponent field 0 means zero (subnormals are flushed). Exponent all-ones with fraction 0 means infinity. Exponent all-ones with fraction ≠ 0 means NaN.
- Special-case priority:
  1. Any NaN, 0/0 or inf/inf: canonical NaN (sign 0, exponent all-ones, fraction MSB only set), oor_out[3]=1.
  2. Finite nonzero / 0: signed infinity, oor_out[2]=1.
  3. inf / finite: signed infinity, oor=0.
  4. finite / inf, or 0 / nonzero: signed zero, oor=0.
- oor_out is fully rewritten with each result; bits not raised are 0.

Test Plan:
- Reset, then x=0x40C0 (6.0), y=0x4040 (3.0), round=00, start pulse -> ready_out drops; 12 edges later valid_out pulses for one cycle with q_out=0x4000, oor_out=0000; ready_out=1.
- x=0x3F80, y=0x4040 (1/3): round=00 -> 0x3EAB; round=01 -> 0x3EAA. With x=0xBF80: round=11 -> 0xBEAB; round=10 -> 0xBEAA.
- Specials: 0x3F80/0x0000 -> 0x7F80, oor=0100. 0x0000/0x0000 -> 0x7FC0, oor=1000. 0x7F80/0x7F80 -> 0x7FC0, oor=1000. 0xC000/0x7F80 -> 0x8000, oor=0000. All with 12-edge latency.
- Range: 0x7F00/0x3F00 with round=00 -> 0x7F80, oor=0001; same with round=01 -> 0x7F7F, oor=0001. 0x0080/0x4000 -> 0x0000, oor=0010.
- Handshake: start_in held high throughout a division -> only one acceptance; the second division starts in the valid_out cycle and its result appears 12 edges later. Operands changed mid-division do not affect the result.
- Reset asserted at edge 5 of a division -> no valid_out pulse; q_out=0, ready_out=1. A new division started afterwards completes correctly.
